// File: rtl/cpu_fetch_pkg.sv
// ============================================================================
// Module : cpu_fetch_pkg
// Brief  : Shared types and constants for the instruction fetch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Word-align a byte address; the low two bits are dropped rather than rounded.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Synchronous FIFO of fetch entries; flush beats push and pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so a push into a full queue is legal in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// Module : inst_fetch_ctrl
// Brief  : Fetch PC owner, ROM sequencer and fetch queue feeding decode.
//          Optional FETCH_PERF_CNT_EN enables the delivered-instruction counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic         fetching;
  logic         q_full;
  logic         q_empty;
  logic         do_push;
  logic         do_pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Redirect overrides every state, including a simultaneous halt.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    state_next = FETCH;
        FETCH:   if (halt) state_next = HALTED;
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    fetching = (state == FETCH);
    halted   = (state == HALTED);
  end

  assign do_pop  = out_valid && out_ready && !redirect_valid;
  assign do_push = fetching && !redirect_valid && !halt && (!q_full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (do_push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  assign rom_addr        = fetch_pc;
  assign push_entry.pc   = fetch_pc;
  assign push_entry.inst = rom_inst;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Queue storage is not reset, so the head is masked while nothing is queued.
  assign out_valid = !q_empty;
  assign out_pc    = q_empty ? 32'h0000_0000 : head.pc;
  assign out_inst  = q_empty ? INST_NOP : head.inst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count_q <= 32'h0000_0000;
    else if (do_pop) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0000_0000;
`endif

endmodule

`default_nettype wire
